// File: rtl/adc_ctrl.sv
// adc_ctrl: scan controller for an 8-bit parallel ADC with a sample stream.
// Optional EOC watchdog: define ADC_EOC_TIMEOUT_EN to enable it.
module adc_ctrl #(
    parameter int NUM_CH   = 3,
    parameter int CONV_GAP = 16,
    parameter int RD_HOLD  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] Data_in,
    input  logic       EOC,
    output logic       A0,
    output logic       A1,
    output logic       CONVST,
    output logic       RD,
    output logic       CS,
    output logic       PD,
    output logic [7:0] sample_data,
    output logic [1:0] sample_ch,
    output logic       sample_valid,
    input  logic       sample_ready,
    output logic       overrun,
    output logic       timeout_err
);

    if (NUM_CH < 1 || NUM_CH > 4) begin : g_bad_num_ch
        $error("adc_ctrl: NUM_CH must be 1..4");
    end
    if (CONV_GAP < 1 || CONV_GAP > 255) begin : g_bad_gap
        $error("adc_ctrl: CONV_GAP must be 1..255");
    end
    if (RD_HOLD < 2 || RD_HOLD > 15) begin : g_bad_hold
        $error("adc_ctrl: RD_HOLD must be 2..15");
    end
    if (TIMEOUT < 2) begin : g_bad_tmo
        $error("adc_ctrl: TIMEOUT must be >= 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        WAIT_EOC,
        READ,
        RELEASE,
        GAP
    } state_t;

    localparam logic [7:0] GAP_LD  = 8'(CONV_GAP);
    localparam logic [7:0] RD_LD   = 8'(RD_HOLD - 1);
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

    state_t     state;
    state_t     state_n;
    logic [7:0] cnt;
    logic [7:0] cnt_n;
    logic [1:0] cur_ch;
    logic [1:0] cur_ch_n;
    logic [1:0] nxt_ch;
    logic [1:0] addr_n;
    logic       load;

`ifdef ADC_EOC_TIMEOUT_EN
    localparam int            TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    // tcnt holds the number of cycles since the CONVST strobe (or since
    // RELEASE was entered); hitting TMO_LAST makes the pulse land
    // exactly TIMEOUT cycles after the strobe.
    logic [TW-1:0] tcnt;
    logic          tmo_hit;
    logic          tmo;

    assign tmo_hit = (tcnt == TMO_LAST);
`endif

    // Channel the ADC mux is pointed at for the following conversion.
    assign nxt_ch = (cur_ch == LAST_CH) ? 2'd0 : cur_ch + 2'd1;

    // Next-state, counter and channel-tracking logic.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        cur_ch_n = cur_ch;
        load     = 1'b0;
`ifdef ADC_EOC_TIMEOUT_EN
        tmo      = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (enable) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt == 8'd0) begin
                    state_n = enable ? CONV : IDLE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            CONV: begin
                state_n = WAIT_EOC;
            end
            WAIT_EOC: begin
                if (!EOC) begin
                    state_n = READ;
                    cnt_n   = RD_LD;
                end
`ifdef ADC_EOC_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo      = 1'b1;
                    state_n  = GAP;
                    cnt_n    = GAP_LD;
                    cur_ch_n = 2'd0;
                end
`endif
            end
            READ: begin
                if (cnt == 8'd0) begin
                    load     = 1'b1;
                    cur_ch_n = nxt_ch;
                    state_n  = RELEASE;
                end else begin
                    cnt_n = cnt - 8'd1;
                end
            end
            RELEASE: begin
                if (EOC) begin
                    state_n = GAP;
                    cnt_n   = GAP_LD;
                end
`ifdef ADC_EOC_TIMEOUT_EN
                else if (tmo_hit) begin
                    tmo      = 1'b1;
                    state_n  = GAP;
                    cnt_n    = GAP_LD;
                    cur_ch_n = 2'd0;
                end
`endif
            end
            default: begin
                state_n = IDLE;
                cnt_n   = 8'd0;
            end
        endcase

        // Address moves to the next channel for the whole read so the
        // mux settles before the following CONVST.
        addr_n = {A1, A0};
        if (state_n == READ) begin
            addr_n = nxt_ch;
        end
`ifdef ADC_EOC_TIMEOUT_EN
        if (tmo) begin
            addr_n = 2'd0;
        end
`endif
    end

    // State, counter and tracked-channel registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            cur_ch <= 2'd0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            cur_ch <= cur_ch_n;
        end
    end

    // ADC strobes, power and address, registered from the next state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            CONVST <= 1'b1;
            CS     <= 1'b1;
            RD     <= 1'b1;
            PD     <= 1'b0;
            A1     <= 1'b0;
            A0     <= 1'b0;
        end else begin
            CONVST <= (state_n != CONV);
            CS     <= (state_n != READ);
            RD     <= (state_n != READ);
            PD     <= (state_n != IDLE);
            A1     <= addr_n[1];
            A0     <= addr_n[0];
        end
    end

    // Sample holding register with overwrite-on-overrun semantics.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sample_data  <= 8'd0;
            sample_ch    <= 2'd0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= load && sample_valid && !sample_ready;
            if (load) begin
                sample_data  <= Data_in;
                sample_ch    <= cur_ch;
                sample_valid <= 1'b1;
            end else if (sample_valid && sample_ready) begin
                sample_valid <= 1'b0;
            end
        end
    end

`ifdef ADC_EOC_TIMEOUT_EN
    // EOC watchdog counter and its error pulse.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcnt        <= '0;
            timeout_err <= 1'b0;
        end else begin
            timeout_err <= tmo;
            if (state_n == WAIT_EOC || state_n == RELEASE) begin
                tcnt <= (state_n == state) ? tcnt + 1'b1 : TW'(1);
            end else begin
                tcnt <= '0;
            end
        end
    end
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_ctrl.sv
// tb_adc_ctrl: directed bench for adc_ctrl with a behavioural ADC model.
// Exercises scan order, overrun, enable drop, mid-read reset, EOC timeout.
module tb_adc_ctrl;

    localparam int NUM_CH   = 3;
    localparam int CONV_GAP = 16;
    localparam int RD_HOLD  = 2;
    localparam int TIMEOUT  = 255;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] Data_in = 8'h00;
    logic       EOC = 1'b1;
    logic       sample_ready = 1'b0;
    logic       A0, A1, CONVST, RD, CS, PD;
    logic [7:0] sample_data;
    logic [1:0] sample_ch;
    logic       sample_valid;
    logic       overrun;
    logic       timeout_err;

    int n_checks = 0;
    int n_errs = 0;
    bit eoc_stuck = 1'b0;

    int cyc = 0;
    int conv_cnt = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    int conv_cyc = 0;
    int tmo_cyc = 0;
    int cv_run = 0;
    int cs_run = 0;
    int rd_run = 0;
    int since_hi = 0;
    bit cs_bad = 1'b0;
    logic [9:0] q[$];

    adc_ctrl #(
        .NUM_CH  (NUM_CH),
        .CONV_GAP(CONV_GAP),
        .RD_HOLD (RD_HOLD),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .enable      (enable),
        .Data_in     (Data_in),
        .EOC         (EOC),
        .A0          (A0),
        .A1          (A1),
        .CONVST      (CONVST),
        .RD          (RD),
        .CS          (CS),
        .PD          (PD),
        .sample_data (sample_data),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #12 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] adc_val(input logic [1:0] a);
        case (a)
            2'd0:    return 8'h12;
            2'd1:    return 8'h34;
            2'd2:    return 8'h56;
            default: return 8'hff;
        endcase
    endfunction

    task automatic check_rst(input string tag);
        check(tag, {CONVST, CS, RD, PD, A1, A0, sample_valid, overrun,
                    timeout_err, sample_ch, sample_data},
              {3'b111, 16'h0000});
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        enable = 1'b0;
        q.delete();
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // Behavioural ADC: samples the address on CONVST fall, answers with
    // EOC low a few cycles later, frees EOC one cycle after RD rises.
    initial begin
        logic [1:0] ca;
        forever begin
            @(negedge CONVST);
            ca = {A1, A0};
            repeat (4) @(posedge clk);
            #1;
            if (!eoc_stuck && resetn) begin
                Data_in = adc_val(ca);
                EOC = 1'b0;
                @(posedge RD);
                @(posedge clk);
                #1;
                EOC = 1'b1;
            end
        end
    end

    // Protocol monitor and sample collector.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (timeout_err) begin
                tmo_cnt++;
                tmo_cyc = cyc;
            end
            if (!resetn) begin
                cv_run = 0;
                cs_run = 0;
                rd_run = 0;
                cs_bad = 1'b0;
                since_hi = 0;
                conv_cnt = 0;
                ovr_cnt = 0;
            end else begin
                if (EOC) begin
                    if (since_hi < 1000) since_hi++;
                end else begin
                    since_hi = 0;
                end
                if (!CONVST) begin
                    if (cv_run == 0) begin
                        conv_cnt++;
                        conv_cyc = cyc;
                        check("conv_gap", 32'(since_hi >= CONV_GAP), 1);
                    end
                    cv_run++;
                end else if (cv_run != 0) begin
                    check("convst_width", cv_run, 1);
                    cv_run = 0;
                end
                if (!CS) begin
                    cs_run++;
                    if (EOC) cs_bad = 1'b1;
                end else if (cs_run != 0) begin
                    check("cs_width", cs_run, RD_HOLD);
                    check("cs_eoc_low", 32'(cs_bad), 0);
                    cs_run = 0;
                    cs_bad = 1'b0;
                end
                if (!RD) begin
                    rd_run++;
                end else if (rd_run != 0) begin
                    check("rd_width", rd_run, RD_HOLD);
                    rd_run = 0;
                end
                if (overrun) ovr_cnt++;
                if (sample_valid && sample_ready) begin
                    q.push_back({sample_ch, sample_data});
                end
            end
        end
    end

    initial begin
        int base;
        int t0;

        do_reset();
        check_rst("rst_init");

        // Free-running scan with the consumer always ready.
        sample_ready = 1'b1;
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("pd_on", 32'(PD), 1);
        check("settle_no_conv", 32'(CONVST), 1);
        for (int i = 0; i < 1000; i++) begin
            if (q.size() >= 4) break;
            @(posedge clk);
            #1;
        end
        check("scan_wait", 32'(q.size() >= 4), 1);
        enable = 1'b0;
        if (q.size() >= 4) begin
            check("scan_s0", 32'(q[0]), 32'h012);
            check("scan_s1", 32'(q[1]), 32'h134);
            check("scan_s2", 32'(q[2]), 32'h256);
            check("scan_s3", 32'(q[3]), 32'h012);
        end
        for (int i = 0; i < 200; i++) begin
            if (!PD) break;
            @(posedge clk);
            #1;
        end
        check("scan_idle_pd", 32'(PD), 0);

        // Consumer stalled across two conversions.
        do_reset();
        sample_ready = 1'b0;
        enable = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (conv_cnt >= 2) break;
            @(posedge clk);
            #1;
        end
        check("ovr_wait", 32'(conv_cnt >= 2), 1);
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!PD) break;
            @(posedge clk);
            #1;
        end
        check("ovr_idle_pd", 32'(PD), 0);
        check("ovr_count", ovr_cnt, 1);
        check("ovr_valid", 32'(sample_valid), 1);
        check("ovr_data", 32'(sample_data), 32'h34);
        check("ovr_ch", 32'(sample_ch), 1);
        sample_ready = 1'b1;
        @(posedge clk);
        #1;
        check("ovr_drain", 32'(sample_valid), 0);

        // Enable dropped while waiting for EOC.
        do_reset();
        sample_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (conv_cnt >= 1) break;
            @(posedge clk);
            #1;
        end
        check("drop_wait", 32'(conv_cnt >= 1), 1);
        enable = 1'b0;
        check("drop_in_wait", 32'(EOC), 1);
        for (int i = 0; i < 200; i++) begin
            if (!PD) break;
            @(posedge clk);
            #1;
        end
        check("drop_idle_pd", 32'(PD), 0);
        check("drop_count", q.size(), 1);
        check("drop_sample", 32'(q.size() > 0 ? q[0] : 10'h3ff), 32'h012);
        repeat (60) @(posedge clk);
        #1;
        check("drop_no_conv", conv_cnt, 1);
        check("drop_pd_off", 32'(PD), 0);

        // Reset asserted in the middle of the second read.
        do_reset();
        sample_ready = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (q.size() >= 1) break;
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 100; i++) begin
            if (!CS) break;
            @(posedge clk);
            #1;
        end
        check("mid_in_read", 32'(CS), 0);
        check("mid_addr", 32'({A1, A0}), 2);
        resetn = 1'b0;
        #1;
        check("mid_cs_rd", 32'({CS, RD}), 32'h3);
        check_rst("mid_rst");
        repeat (3) @(posedge clk);
        #1;
        q.delete();
        resetn = 1'b1;
        enable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (q.size() >= 1) break;
            @(posedge clk);
            #1;
        end
        check("mid_first", 32'(q.size() > 0 ? q[0] : 10'h3ff), 32'h012);
        enable = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!PD) break;
            @(posedge clk);
            #1;
        end
        check("mid_idle_pd", 32'(PD), 0);

`ifdef ADC_EOC_TIMEOUT_EN
        // ADC never answers: watchdog must fire and restart the scan.
        eoc_stuck = 1'b1;
        do_reset();
        sample_ready = 1'b1;
        enable = 1'b1;
        base = tmo_cnt;
        for (int i = 0; i < 100; i++) begin
            if (conv_cnt >= 1) break;
            @(posedge clk);
            #1;
        end
        t0 = conv_cyc;
        for (int i = 0; i < 400; i++) begin
            if (tmo_cnt > base) break;
            @(posedge clk);
            #1;
        end
        check("tmo_seen", 32'(tmo_cnt > base), 1);
        check("tmo_latency", tmo_cyc - t0, TIMEOUT);
        check("tmo_no_valid", 32'(sample_valid), 0);
        check("tmo_no_sample", q.size(), 0);
        for (int i = 0; i < 100; i++) begin
            if (conv_cnt >= 2) break;
            @(posedge clk);
            #1;
        end
        check("tmo_reconv", 32'(conv_cnt >= 2), 1);
        check("tmo_regap", 32'(conv_cyc - tmo_cyc >= CONV_GAP), 1);
        enable = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!PD) break;
            @(posedge clk);
            #1;
        end
        check("tmo_idle_pd", 32'(PD), 0);
        eoc_stuck = 1'b0;
`else
        base = 0;
        t0 = 0;
        check("no_tmo", tmo_cnt + base + t0, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errs);
        $finish;
    end

endmodule
